// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet receive path.
package eth_pkg;

   typedef enum logic [2:0] {
      ST_DROP,
      ST_IDLE,
      ST_PREAMBLE,
      ST_HEADER,
      ST_PAYLOAD
   } eth_rx_state_e;

   localparam logic [47:0] ETH_BROADCAST = 48'hFFFF_FFFF_FFFF;
   localparam int          ETH_HDR_LEN   = 14;

   // CRC register kept MSB-first; wire bits are fed LSB-first, which gives the
   // reflected Ethernet CRC with the classic C704DD7B good-frame residue.
   localparam logic [31:0] CRC32_POLY    = 32'h04C1_1DB7;
   localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC32_RESIDUE = 32'hC704_DD7B;

endpackage

// File: rtl/eth_crc32_nibble.sv
// Combinational CRC-32 update for one MII nibble (bit 0 first on the wire).
module eth_crc32_nibble
   import eth_pkg::*;
(
   input  logic [31:0] crc_i,
   input  logic [3:0]  nib_i,
   output logic [31:0] crc_o
);

   logic [31:0] c;

   // Four serial LFSR steps, one per nibble bit in wire order.
   always_comb begin
      c = crc_i;
      for (int i = 0; i < 4; i++) begin
         if (c[31] ^ nib_i[i]) c = {c[30:0], 1'b0} ^ CRC32_POLY;
         else                  c = {c[30:0], 1'b0};
      end
      crc_o = c;
   end

endmodule

// File: rtl/eth_rx.sv
// MII receive stage: preamble/SFD strip, header parse + filter, payload to
// byte-wide AXI-Stream. Optional FCS check and strip under `ETH_RX_CRC_EN`.
module eth_rx
   import eth_pkg::*;
#(
   parameter int PROMISC   = 0,
   parameter int MIN_FRAME = 64,
   parameter int MAX_FRAME = 1518
) (
   input  logic        rx_clk,
   input  logic        rst,
   input  logic [3:0]  rxd,
   input  logic        rx_en,
   input  logic [47:0] local_mac,
   output logic [7:0]  m_axis_tdata,
   output logic        m_axis_tvalid,
   output logic        m_axis_tlast,
   output logic        m_axis_tuser,
   output logic [47:0] rx_src_mac,
   output logic [15:0] rx_eth_type,
   output logic        frame_drop
);

   // Delay-line depth: one byte holds back tlast; four more hide the FCS.
`ifdef ETH_RX_CRC_EN
   localparam int DLY = 5;
`else
   localparam int DLY = 1;
`endif
   localparam logic [2:0]  DLY_L    = 3'(DLY);
   localparam logic [10:0] MIN_L    = 11'(MIN_FRAME);
   localparam logic [10:0] MAX_L    = 11'(MAX_FRAME);
   localparam logic [10:0] HDR_LAST = 11'(ETH_HDR_LEN - 1);

   eth_rx_state_e        state_q, state_d;
   logic [3:0]           lo_q, lo_d;        // pending low nibble
   logic                 odd_q, odd_d;      // low nibble held, waiting for high
   logic [10:0]          cnt_q, cnt_d;      // bytes since SFD, saturating
   logic [103:0]         hdr_q, hdr_d;      // first 13 header bytes, oldest on top
   logic [DLY-1:0][7:0]  dly_q, dly_d;      // [0] newest, [DLY-1] oldest
   logic [2:0]           fill_q, fill_d;
   logic                 emit_q, emit_d;    // at least one beat sent this frame
   logic [47:0]          src_q, src_d;
   logic [15:0]          type_q, type_d;
   logic [7:0]           tdata_q, tdata_d;
   logic                 tvalid_q, tvalid_d;
   logic                 tlast_q, tlast_d;
   logic                 tuser_q, tuser_d;
   logic                 drop_q, drop_d;

   logic [7:0]   byte_w;
   logic [111:0] hdr_full_w;
   logic [47:0]  dst_w;
   logic         accept_w;
   logic [10:0]  cnt_inc_w;
   logic         len_err_w;
   logic         crc_err_w;

   assign byte_w     = {rxd, lo_q};
   assign hdr_full_w = {hdr_q, byte_w};
   assign dst_w      = hdr_full_w[111:64];
   assign accept_w   = (PROMISC != 0) || (dst_w == local_mac) || (dst_w == ETH_BROADCAST);
   assign cnt_inc_w  = (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;
   assign len_err_w  = (cnt_q < MIN_L) || (cnt_q > MAX_L);

`ifdef ETH_RX_CRC_EN
   logic [31:0] crc_q, crc_d, crc_nxt_w;

   eth_crc32_nibble u_crc (
      .crc_i (crc_q),
      .nib_i (rxd),
      .crc_o (crc_nxt_w)
   );

   assign crc_err_w = (crc_q != CRC32_RESIDUE);
`else
   assign crc_err_w = 1'b0;
`endif

   // Next-state and output decode for the receive FSM.
   always_comb begin
      state_d  = state_q;
      lo_d     = lo_q;
      odd_d    = odd_q;
      cnt_d    = cnt_q;
      hdr_d    = hdr_q;
      dly_d    = dly_q;
      fill_d   = fill_q;
      emit_d   = emit_q;
      src_d    = src_q;
      type_d   = type_q;
      tdata_d  = tdata_q;
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
      tuser_d  = 1'b0;
      drop_d   = 1'b0;
`ifdef ETH_RX_CRC_EN
      crc_d    = crc_q;
`endif
      unique case (state_q)
         ST_DROP: if (!rx_en) state_d = ST_IDLE;
         // Anything but a preamble nibble mid-burst is ignored until rx_en drops.
         ST_IDLE: if (rx_en) state_d = (rxd == 4'h5) ? ST_PREAMBLE : ST_DROP;
         ST_PREAMBLE: begin
            if (!rx_en) begin
               state_d = ST_IDLE;
            end else if (rxd == 4'hD) begin
               state_d = ST_HEADER;
               odd_d   = 1'b0;
               cnt_d   = '0;
               fill_d  = '0;
               emit_d  = 1'b0;
`ifdef ETH_RX_CRC_EN
               crc_d   = CRC32_INIT;
`endif
            end else if (rxd != 4'h5) begin
               state_d = ST_DROP;
            end
         end
         ST_HEADER: begin
            if (!rx_en) begin
               state_d = ST_IDLE;
               drop_d  = 1'b1;
            end else begin
`ifdef ETH_RX_CRC_EN
               crc_d = crc_nxt_w;
`endif
               if (!odd_q) begin
                  lo_d  = rxd;
                  odd_d = 1'b1;
               end else begin
                  odd_d = 1'b0;
                  cnt_d = cnt_inc_w;
                  hdr_d = {hdr_q[95:0], byte_w};
                  if (cnt_q == HDR_LAST) begin
                     if (accept_w) begin
                        state_d = ST_PAYLOAD;
                        src_d   = hdr_full_w[63:16];
                        type_d  = hdr_full_w[15:0];
                     end else begin
                        state_d = ST_DROP;
                        drop_d  = 1'b1;
                     end
                  end
               end
            end
         end
         ST_PAYLOAD: begin
            if (!rx_en) begin
               state_d = ST_IDLE;
               if (emit_q) begin
                  tvalid_d = 1'b1;
                  tlast_d  = 1'b1;
                  tdata_d  = dly_q[DLY-1];
                  tuser_d  = odd_q | len_err_w | crc_err_w;
               end else begin
                  drop_d = 1'b1;
               end
            end else begin
`ifdef ETH_RX_CRC_EN
               crc_d = crc_nxt_w;
`endif
               if (!odd_q) begin
                  lo_d  = rxd;
                  odd_d = 1'b1;
               end else begin
                  odd_d = 1'b0;
                  cnt_d = cnt_inc_w;
                  if (fill_q == DLY_L) begin
                     tvalid_d = 1'b1;
                     tdata_d  = dly_q[DLY-1];
                     emit_d   = 1'b1;
                  end else begin
                     fill_d = fill_q + 3'd1;
                  end
                  dly_d[0] = byte_w;
                  for (int i = 1; i < DLY; i++) dly_d[i] = dly_q[i-1];
               end
            end
         end
         default: state_d = ST_DROP;
      endcase
   end

   // State and output registers; reset parks in DROP with all outputs low.
   always_ff @(posedge rx_clk) begin
      if (rst) begin
         state_q  <= ST_DROP;
         lo_q     <= '0;
         odd_q    <= 1'b0;
         cnt_q    <= '0;
         hdr_q    <= '0;
         dly_q    <= '0;
         fill_q   <= '0;
         emit_q   <= 1'b0;
         src_q    <= '0;
         type_q   <= '0;
         tdata_q  <= '0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
         tuser_q  <= 1'b0;
         drop_q   <= 1'b0;
`ifdef ETH_RX_CRC_EN
         crc_q    <= CRC32_INIT;
`endif
      end else begin
         state_q  <= state_d;
         lo_q     <= lo_d;
         odd_q    <= odd_d;
         cnt_q    <= cnt_d;
         hdr_q    <= hdr_d;
         dly_q    <= dly_d;
         fill_q   <= fill_d;
         emit_q   <= emit_d;
         src_q    <= src_d;
         type_q   <= type_d;
         tdata_q  <= tdata_d;
         tvalid_q <= tvalid_d;
         tlast_q  <= tlast_d;
         tuser_q  <= tuser_d;
         drop_q   <= drop_d;
`ifdef ETH_RX_CRC_EN
         crc_q    <= crc_d;
`endif
      end
   end

   assign m_axis_tdata  = tdata_q;
   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tlast  = tlast_q;
   assign m_axis_tuser  = tuser_q;
   assign rx_src_mac    = src_q;
   assign rx_eth_type   = type_q;
   assign frame_drop    = drop_q;

endmodule

// File: tb/tb_eth_rx.sv
// Scoreboard bench for eth_rx: frames are built as byte lists, a byte-level
// model pushes expected beats, and a monitor pops them as the DUT emits.
module tb_eth_rx;

   logic        rx_clk = 1'b0;
   logic        rst    = 1'b1;
   logic [3:0]  rxd    = '0;
   logic        rx_en  = 1'b0;
   logic [47:0] local_mac = 48'h000A_3501_0203;
   logic [7:0]  m_axis_tdata;
   logic        m_axis_tvalid, m_axis_tlast, m_axis_tuser;
   logic [47:0] rx_src_mac;
   logic [15:0] rx_eth_type;
   logic        frame_drop;

   eth_rx dut (
      .rx_clk        (rx_clk),
      .rst           (rst),
      .rxd           (rxd),
      .rx_en         (rx_en),
      .local_mac     (local_mac),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tuser  (m_axis_tuser),
      .rx_src_mac    (rx_src_mac),
      .rx_eth_type   (rx_eth_type),
      .frame_drop    (frame_drop)
   );

   always #5 rx_clk = ~rx_clk;

`ifdef ETH_RX_CRC_EN
   localparam int D = 5;  localparam bit CRC = 1'b1; localparam int UNI_BEATS = 46;
`else
   localparam int D = 1;  localparam bit CRC = 1'b0; localparam int UNI_BEATS = 50;
`endif

   typedef struct {logic [7:0] d; logic l; logic u;} beat_t;
   beat_t       exp_q[$];
   beat_t       mon_e;
   logic [7:0]  frm[$];
   int          checks = 0, errors = 0, beats = 0, drops = 0, exp_drops = 0;
   logic [47:0] exp_src = '0;
   logic [15:0] exp_type = '0;
   bit          mon_en = 1'b0;
   localparam logic [47:0] SRC_A = 48'h0011_2233_4455;
   localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pop one expectation per beat; tlast/tuser must stay low between beats.
   always @(negedge rx_clk) begin
      if (mon_en) begin
         if (frame_drop === 1'b1) drops++;
         if (m_axis_tvalid === 1'b1) begin
            beats++;
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_beat: got data %0h, expected no beat", m_axis_tdata);
            end else begin
               mon_e = exp_q.pop_front();
               check("beat_data", m_axis_tdata, mon_e.d);
               check("beat_tlast", m_axis_tlast, mon_e.l);
               check("beat_tuser", m_axis_tuser, mon_e.u);
            end
         end else begin
            check("idle_tlast_tuser", {m_axis_tlast, m_axis_tuser}, 2'b00);
         end
      end
   end

   // Reference Ethernet FCS, reflected byte-wise form.
   function automatic logic [31:0] fcs_of();
      logic [31:0] c = 32'hFFFF_FFFF;
      foreach (frm[i]) begin
         c ^= {24'd0, frm[i]};
         for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
      return ~c;
   endfunction

   task automatic build(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] typ,
                        input int plen, input bit incr, input bit fcs, input bit corrupt);
      logic [31:0] c;
      frm.delete();
      for (int i = 0; i < 6; i++) frm.push_back(dst[47-8*i -: 8]);
      for (int i = 0; i < 6; i++) frm.push_back(src[47-8*i -: 8]);
      frm.push_back(typ[15:8]);
      frm.push_back(typ[7:0]);
      for (int i = 0; i < plen; i++) frm.push_back(incr ? 8'(i) : 8'($urandom));
      if (fcs) begin
         c = fcs_of();
         if (corrupt) c[0] = ~c[0];
         for (int i = 0; i < 4; i++) frm.push_back(c[8*i +: 8]);
      end
   endtask

   // Byte-level model: header filter, then all but the last D bytes go out.
   task automatic expect_frame(input bit extra, input bit crc_ok);
      int n, np;
      logic [47:0] dst;
      logic usr;
      beat_t b;
      n = frm.size();
      if (n < 14) begin exp_drops++; return; end
      dst = {frm[0], frm[1], frm[2], frm[3], frm[4], frm[5]};
      if (!(dst == local_mac || dst == BCAST)) begin exp_drops++; return; end
      exp_src  = {frm[6], frm[7], frm[8], frm[9], frm[10], frm[11]};
      exp_type = {frm[12], frm[13]};
      np = n - 14;
      if (np <= D) begin exp_drops++; return; end
      usr = extra || (n < 64) || (n > 1518) || (CRC && !crc_ok);
      for (int i = 0; i <= np - D; i++) begin
         b.d = frm[14+i];
         b.l = (i == np - D);
         b.u = b.l && usr;
         exp_q.push_back(b);
      end
   endtask

   task automatic nib(input logic [3:0] n);
      @(posedge rx_clk); #1; rx_en = 1'b1; rxd = n;
   endtask

   task automatic gap(input int c);
      repeat (c) begin @(posedge rx_clk); #1; rx_en = 1'b0; rxd = '0; end
   endtask

   task automatic preamble();
      repeat (15) nib(4'h5);
      nib(4'hD);
   endtask

   task automatic send(input bit extra);
      preamble();
      foreach (frm[i]) begin nib(frm[i][3:0]); nib(frm[i][7:4]); end
      if (extra) nib(4'($urandom));
      gap(12);
   endtask

   task automatic after_frame(input string tag);
      check({tag, "_pending_beats"}, exp_q.size(), 0);
      check({tag, "_drops"}, drops, exp_drops);
      check({tag, "_src_mac"}, rx_src_mac, exp_src);
      check({tag, "_eth_type"}, rx_eth_type, exp_type);
   endtask

   task automatic run(input string tag, input bit extra, input bit crc_ok);
      expect_frame(extra, crc_ok);
      send(extra);
      after_frame(tag);
   endtask

   initial begin
      int b0, d0, sel, plen;
      bit extra, corrupt;
      logic [47:0] dst;

      repeat (3) @(posedge rx_clk);
      @(negedge rx_clk);
      check("rst_tvalid", m_axis_tvalid, 0);
      check("rst_tlast", m_axis_tlast, 0);
      check("rst_tuser", m_axis_tuser, 0);
      check("rst_tdata", m_axis_tdata, 0);
      check("rst_src", rx_src_mac, 0);
      check("rst_type", rx_eth_type, 0);
      check("rst_drop", frame_drop, 0);
      @(posedge rx_clk); #1; rst = 1'b0;
      mon_en = 1'b1;
      gap(3);

      // Unicast reference frame
      build(local_mac, SRC_A, 16'h0800, 46, 1'b1, 1'b1, 1'b0);
      b0 = beats;
      run("unicast", 1'b0, 1'b1);
      check("unicast_beat_count", beats - b0, UNI_BEATS);
      check("unicast_type", rx_eth_type, 16'h0800);
      check("unicast_src", rx_src_mac, SRC_A);

      // Foreign unicast filtered, then broadcast accepted
      build(48'h000A_3501_0204, 48'h0A0B_0C0D_0E0F, 16'h0806, 46, 1'b0, 1'b1, 1'b0);
      d0 = drops; b0 = beats;
      run("filtered", 1'b0, 1'b1);
      check("filtered_drop_pulse", drops - d0, 1);
      check("filtered_no_beats", beats - b0, 0);
      check("filtered_src_held", rx_src_mac, SRC_A);
      build(BCAST, 48'h0A0B_0C0D_0E0F, 16'h0806, 46, 1'b0, 1'b1, 1'b0);
      run("broadcast", 1'b0, 1'b1);

      // Bad FCS, runt, giant, dribble nibble
      build(local_mac, SRC_A, 16'h0800, 46, 1'b1, 1'b1, 1'b1);
      run("bad_fcs", 1'b0, 1'b0);
      build(local_mac, SRC_A, 16'h0800, 2, 1'b0, 1'b1, 1'b0);
      run("runt20", 1'b0, 1'b1);
      build(local_mac, SRC_A, 16'h88B5, 1501, 1'b0, 1'b1, 1'b0);
      run("giant1519", 1'b0, 1'b1);
      build(local_mac, SRC_A, 16'h0800, 46, 1'b0, 1'b1, 1'b0);
      run("extra_nibble", 1'b1, 1'b1);

      // Delay-line boundaries: exactly D bytes after header, then D+1
      build(local_mac, SRC_A, 16'h0101, D, 1'b0, 1'b0, 1'b0);
      run("payload_eq_d", 1'b0, 1'b0);
      build(local_mac, SRC_A, 16'h0102, D + 1, 1'b0, 1'b0, 1'b0);
      run("payload_d_plus1", 1'b0, 1'b0);

      // Truncated header
      build(local_mac, SRC_A, 16'h0800, 0, 1'b0, 1'b0, 1'b0);
      while (frm.size() > 9) void'(frm.pop_back());
      run("trunc_hdr", 1'b0, 1'b0);

      // Reset mid-payload with rx_en held high
      build(local_mac, 48'h0600_0000_0001, 16'h86DD, 30, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 10 - D; i++) exp_q.push_back('{frm[14+i], 1'b0, 1'b0});
      preamble();
      for (int i = 0; i < 24; i++) begin nib(frm[i][3:0]); nib(frm[i][7:4]); end
      @(posedge rx_clk); #1; rst = 1'b1; rx_en = 1'b1; rxd = frm[24][3:0];
      @(posedge rx_clk); #1; rst = 1'b0; rxd = frm[24][7:4];
      @(negedge rx_clk);
      check("mrst_tvalid", m_axis_tvalid, 0);
      check("mrst_tlast", m_axis_tlast, 0);
      check("mrst_tuser", m_axis_tuser, 0);
      check("mrst_tdata", m_axis_tdata, 0);
      check("mrst_src", rx_src_mac, 0);
      check("mrst_type", rx_eth_type, 0);
      check("mrst_drop", frame_drop, 0);
      exp_src = '0; exp_type = '0;
      for (int i = 25; i < frm.size(); i++) begin nib(frm[i][3:0]); nib(frm[i][7:4]); end
      gap(12);
      after_frame("mid_reset");
      build(local_mac, SRC_A, 16'h0800, 46, 1'b1, 1'b1, 1'b0);
      run("post_reset", 1'b0, 1'b1);

      // Broken preamble: 55 55 then a 3 nibble
      d0 = drops; b0 = beats;
      repeat (4) nib(4'h5);
      nib(4'h3);
      repeat (10) nib(4'($urandom));
      gap(12);
      after_frame("bad_preamble");
      check("bad_preamble_drop", drops - d0, 0);
      check("bad_preamble_beats", beats - b0, 0);

      // Randomized traffic
      for (int f = 0; f < 24; f++) begin
         sel     = $urandom_range(0, 3);
         dst     = (sel < 2) ? local_mac : (sel == 2) ? BCAST : {16'h0200, 32'($urandom)};
         plen    = $urandom_range(0, 80);
         corrupt = ($urandom_range(0, 3) == 0);
         extra   = ($urandom_range(0, 4) == 0);
         build(dst, {16'h0200, 32'($urandom)}, 16'($urandom), plen, 1'b0, 1'b1, corrupt);
         if ($urandom_range(0, 5) == 0)
            while (frm.size() > 13) void'(frm.pop_back());
         run("random", extra, !corrupt);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/eth_rx.md
# eth_rx

Receive-side MII stage of the Ethernet MAC: takes the 4-bit `rxd`/`rx_en` nibble stream from the PHY and strips preamble/SFD. It assembles bytes, parses and filters the 14-byte Ethernet header, and delivers the payload as a byte-wide AXI-Stream master. It is the receive counterpart of the MAC's transmit path and feeds the upper protocol layers directly. The output cannot stall because MII has no backpressure.

## Interface
- `PROMISC`, 0: 1 accepts every destination MAC; 0 accepts only `local_mac` or broadcast.
- `MIN_FRAME`, 64: minimum legal frame length in bytes, dst MAC through FCS.
- `MAX_FRAME`, 1518: maximum legal frame length in bytes, dst MAC through FCS.
- `rx_clk`  in  1  PHY receive clock; the only clock. Synchronous, active-high reset.
- `rst`  in  1  synchronous active-high reset.
- `rxd`  in  4  MII receive nibble, low nibble of each byte first.
- `rx_en`  in  1  receive data valid.
- `local_mac`  in  48  station address; `local_mac[47:40]` is the first byte on the wire.
- `m_axis_tdata`  out  8  payload byte.
- `m_axis_tvalid`  out  1  byte valid, single-cycle pulse per byte.
- `m_axis_tlast`  out  1  last payload byte of the frame.
- `m_axis_tuser`  out  1  frame error; meaningful only with `tlast`.
- `rx_src_mac`  out  48  source MAC of the current/last accepted frame.
- `rx_eth_type`  out  16  EtherType of the current/last accepted frame.
- `frame_drop`  out  1  one-cycle pulse when a frame is discarded by the header filter or is shorter than 14 bytes.

## Operation
- Reset values: all outputs 0; state DROP.
- States:
  - DROP→IDLE when `rx_en`=0.
  - IDLE→PREAMBLE when `rx_en`=1 and `rxd`=5.
  - PREAMBLE: stays on 5. Goes to HEADER on `rxd`=D after ≥1 nibble of 5. Any other nibble → DROP, no `frame_drop`.
  - HEADER: collects 14 bytes into dst/src/type registers. After byte 14 → PAYLOAD if accepted, else DROP with `frame_drop`.
  - PAYLOAD → IDLE on `rx_en` falling.
- `rx_en` falling in HEADER → IDLE with a `frame_drop` pulse. No stream output.
- Byte assembly: even nibble → `byte[3:0]`, odd nibble → `byte[7:4]`. The byte completes on the odd nibble.
- Accept condition: `PROMISC`=1, or dst = `local_mac`, or dst = FF:FF:FF:FF:FF:FF.
- `rx_src_mac`/`rx_eth_type` update in the cycle the 14th header byte completes, and only for accepted frames. They hold otherwise.
- Payload bytes pass through a delay line of depth D, so that the final byte can carry `tlast`. D=1 without CRC and D=5 with CRC. A byte is emitted when it is pushed out by a newer byte.
- End of frame (first PAYLOAD cycle with `rx_en`=0): the oldest held byte is emitted with `tlast`=1. Remaining held bytes are discarded (the FCS when CRC is enabled).
- A frame with zero emitted payload bytes (D bytes or fewer after the header) produces no beat and a `frame_drop` pulse.
- `tuser`=1 on the `tlast` beat if any of the following holds:
  - odd nibble count;
  - length < `MIN_FRAME`;
  - length > `MAX_FRAME`;
  - CRC error (CRC build only).
- Byte counter: 11 bits, saturating at 2047.

## Timing
- Output beat is registered: `tvalid` rises one cycle after the odd nibble that pushes a byte out of the delay line.
- Without CRC, the first payload byte appears after its successor completes.
- Beats are at least 2 cycles apart.
- `tlast` beat is one cycle after `rx_en` falls.
- `rx_en`=1 in the same cycle as `rst`: reset wins. The block sits in DROP until `rx_en` is low, so a frame cut by reset yields no beats.
- Back-to-back frames need ≥1 cycle of `rx_en`=0. The IFG is not checked.

## Configuration
- `ETH_RX_CRC_EN` defined:
  - CRC-32 (poly 04C11DB7, init FFFFFFFF, reflected) is computed nibble-wise over dst MAC through FCS.
  - A final register value other than the residue C704DD7B sets `tuser`.
  - D=5; the 4 FCS bytes are stripped.
- `ETH_RX_CRC_EN` undefined:
  - No CRC logic.
  - D=1; the FCS bytes are delivered as the last 4 payload bytes.

## Structure
- Package `eth_pkg` holds:
  - the state enum;
  - `ETH_BROADCAST`, `ETH_HDR_LEN`=14;
  - `CRC32_POLY`, `CRC32_INIT`, `CRC32_RESIDUE`.
- Sub-module `eth_crc32_nibble` provides the combinational 4-bit CRC update. It is instantiated only under `ETH_RX_CRC_EN`.

## Test plan
- Unicast frame: `local_mac`=00:0A:35:01:02:03, 7×55+D5 preamble, type 0800, payload 00..2D (46 B), valid FCS.
  - Expect 46 beats (CRC build), `tlast` on 2D, `tuser`=0, `rx_eth_type`=0800.
  - Without CRC, expect 50 beats.
- Dst 00:0A:35:01:02:04, `PROMISC`=0: zero beats, one `frame_drop` pulse, `rx_src_mac` unchanged. Repeat with dst FF..FF: frame accepted.
- Same frame with FCS LSB flipped (CRC build): 46 beats, `tuser`=1 on `tlast`.
- 20-byte frame: `tuser`=1 (runt). 1519-byte frame: `tuser`=1. Frame with one extra nibble: `tuser`=1.
- `rst` pulse mid-payload while `rx_en` stays high:
  - no further beats;
  - all outputs 0;
  - next frame after `rx_en` low is received correctly.
- Preamble 55 55 then 0x3 nibble: DROP, no beats, no `frame_drop`.
